// File: rtl/comp_sar_ctrl_if.sv
// Handshake/bus bundle between the SAR sequencer and its environment.
// The environment (master) drives control and comparator; the sequencer (slave) drives the rest.
interface comp_sar_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             ena;
    logic             start;
    logic             comp_in;
    logic             sample_en;
    logic [WIDTH-1:0] dac_code;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             result_valid;

    modport master (
        output ena, start, comp_in,
        input  sample_en, dac_code, busy, done, result, result_valid
    );

    modport slave (
        input  ena, start, comp_in,
        output sample_en, dac_code, busy, done, result, result_valid
    );
endinterface

// File: rtl/comp_sar_ctrl.sv
// Successive-approximation sequencer around the on-chip comparator.
// Optional macro COMP_SYNC_EN: two-flop comparator synchronizer, settle window +2 cycles.
module comp_sar_ctrl #(
    parameter int WIDTH         = 8,
    parameter int SAMPLE_CYCLES = 2,
    parameter int SETTLE_CYCLES = 3
) (
    input logic           clk,
    input logic           rst,
    comp_sar_ctrl_if.slave bus
);
    localparam int SAMPLE_LOAD = SAMPLE_CYCLES - 1;
`ifdef COMP_SYNC_EN
    localparam int SETTLE_LOAD = SETTLE_CYCLES + 1;
`else
    localparam int SETTLE_LOAD = SETTLE_CYCLES - 1;
`endif
    localparam int CMAX = (SAMPLE_LOAD > SETTLE_LOAD) ? SAMPLE_LOAD : SETTLE_LOAD;
    localparam int CW   = $clog2(CMAX + 2);
    localparam int BW   = $clog2(WIDTH);

    typedef enum logic [2:0] {
        IDLE, SAMPLE, SETTLE, DECIDE, DONE
    } state_t;

    state_t           state_q, state_n;
    logic [CW-1:0]    cnt_q, cnt_n;
    logic [BW-1:0]    bit_q, bit_n;
    logic [WIDTH-1:0] code_q, code_n;
    logic [WIDTH-1:0] result_q, result_n;
    logic [WIDTH-1:0] resolved;
    logic             sample_q, sample_n;
    logic             busy_q, busy_n;
    logic             done_q, done_n;
    logic             valid_q, valid_n;
    logic             comp;

`ifdef COMP_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[0], bus.comp_in};
    end

    assign comp = sync_q[1];
`else
    assign comp = bus.comp_in;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            bit_q    <= '0;
            code_q   <= '0;
            result_q <= '0;
            sample_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_n;
            cnt_q    <= cnt_n;
            bit_q    <= bit_n;
            code_q   <= code_n;
            result_q <= result_n;
            sample_q <= sample_n;
            busy_q   <= busy_n;
            done_q   <= done_n;
            valid_q  <= valid_n;
        end
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        bit_n    = bit_q;
        code_n   = code_q;
        result_n = result_q;
        sample_n = sample_q;
        done_n   = 1'b0;
        valid_n  = valid_q;
        resolved = code_q;
        if (!comp) resolved[bit_q] = 1'b0;

        unique case (state_q)
            IDLE: begin
                code_n   = '0;
                sample_n = 1'b0;
                if (bus.start && bus.ena) begin
                    state_n  = SAMPLE;
                    cnt_n    = CW'(SAMPLE_LOAD);
                    sample_n = 1'b1;
                    valid_n  = 1'b0;
                end
            end
            SAMPLE: begin
                sample_n = 1'b1;
                if (cnt_q == '0) begin
                    sample_n = 1'b0;
                    bit_n    = BW'(WIDTH - 1);
                    code_n   = {1'b1, {(WIDTH-1){1'b0}}};
                    cnt_n    = CW'(SETTLE_LOAD);
                    state_n  = SETTLE;
                end else begin
                    cnt_n = cnt_q - 1'b1;
                end
            end
            SETTLE: begin
                if (cnt_q == '0) state_n = DECIDE;
                else             cnt_n   = cnt_q - 1'b1;
            end
            DECIDE: begin
                if (bit_q == '0) begin
                    result_n = resolved;
                    valid_n  = 1'b1;
                    done_n   = 1'b1;
                    code_n   = '0;
                    state_n  = DONE;
                end else begin
                    code_n                = resolved;
                    code_n[bit_q - 1'b1]  = 1'b1;
                    bit_n                 = bit_q - 1'b1;
                    cnt_n                 = CW'(SETTLE_LOAD);
                    state_n               = SETTLE;
                end
            end
            DONE: begin
                code_n  = '0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // Disable aborts without touching the published result.
        if (!bus.ena) begin
            state_n  = IDLE;
            cnt_n    = '0;
            sample_n = 1'b0;
            code_n   = '0;
            done_n   = 1'b0;
            result_n = result_q;
            valid_n  = valid_q;
        end

        busy_n = (state_n != IDLE);
    end

    assign bus.sample_en    = sample_q;
    assign bus.dac_code     = code_q;
    assign bus.busy         = busy_q;
    assign bus.done         = done_q;
    assign bus.result       = result_q;
    assign bus.result_valid = valid_q;
endmodule

// File: tb/tb_comp_sar_ctrl.sv
// Directed self-checking bench for comp_sar_ctrl with an ideal comparator model.
// Latency constants follow the COMP_SYNC_EN build setting.
module tb_comp_sar_ctrl;
`ifdef COMP_SYNC_EN
    localparam int N = 50;
`else
    localparam int N = 34;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] vin = 8'h00;

    int tests = 0;
    int fails = 0;

    int lat, ntr, sen, dones;
    logic [7:0] tr [16];
    logic [7:0] res_cap;
    logic       rv_cap;

    comp_sar_ctrl_if #(.WIDTH(8)) bus ();

    comp_sar_ctrl #(
        .WIDTH(8),
        .SAMPLE_CYCLES(2),
        .SETTLE_CYCLES(3)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    assign bus.comp_in = (vin >= bus.dac_code);

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Runs one conversion; optional extra start pulse at cycle poke_at.
    task automatic conv_run(input logic [7:0] v, input int poke_at);
        logic [7:0] prev;
        vin = v;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        lat = -1; ntr = 0; dones = 0;
        sen = bus.sample_en ? 1 : 0;
        prev = bus.dac_code;
        res_cap = 8'h00; rv_cap = 1'b0;
        for (int i = 1; i <= N + 10; i++) begin
            cyc();
            bus.start = (i == poke_at);
            if (bus.sample_en) sen++;
            if (bus.dac_code != prev && bus.dac_code != 8'h00 && ntr < 16) begin
                tr[ntr] = bus.dac_code;
                ntr++;
            end
            prev = bus.dac_code;
            if (bus.done) begin
                dones++;
                if (lat < 0) begin
                    lat = i;
                    res_cap = bus.result;
                    rv_cap = bus.result_valid;
                end
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        cyc(); cyc();
        tests++;
        if ({bus.sample_en, bus.dac_code, bus.busy, bus.done, bus.result, bus.result_valid} !== 20'h0) begin
            $display("FAIL reset_outputs: got %h want 0",
                     {bus.sample_en, bus.dac_code, bus.busy, bus.done, bus.result, bus.result_valid});
            fails++;
        end
        rst = 1'b0;
        cyc(); cyc();
        tests++;
        if (bus.busy !== 1'b0) begin
            $display("FAIL idle_busy: got %b want 0", bus.busy);
            fails++;
        end
    endtask

    task automatic test_vin_a5();
        logic [7:0] exp_tr [8];
        exp_tr = '{8'h80, 8'hC0, 8'hA0, 8'hB0, 8'hA8, 8'hA4, 8'hA6, 8'hA5};
        conv_run(8'hA5, 0);
        tests++;
        if (ntr !== 8) begin
            $display("FAIL a5_trial_count: got %0d want 8", ntr);
            fails++;
        end
        for (int k = 0; k < 8; k++) begin
            tests++;
            if (tr[k] !== exp_tr[k]) begin
                $display("FAIL a5_trial%0d: got %h want %h", k, tr[k], exp_tr[k]);
                fails++;
            end
        end
        tests++;
        if (lat !== N) begin
            $display("FAIL a5_latency: got %0d want %0d", lat, N);
            fails++;
        end
        tests++;
        if (res_cap !== 8'hA5 || rv_cap !== 1'b1) begin
            $display("FAIL a5_result: got %h/%b want a5/1", res_cap, rv_cap);
            fails++;
        end
        tests++;
        if (sen !== 2) begin
            $display("FAIL a5_sample_cycles: got %0d want 2", sen);
            fails++;
        end
        tests++;
        if (dones !== 1) begin
            $display("FAIL a5_done_count: got %0d want 1", dones);
            fails++;
        end
    endtask

    task automatic test_boundaries();
        conv_run(8'h00, 0);
        tests++;
        if (res_cap !== 8'h00 || lat !== N) begin
            $display("FAIL vin00: got %h lat %0d want 00 lat %0d", res_cap, lat, N);
            fails++;
        end
        conv_run(8'hFF, 0);
        tests++;
        if (res_cap !== 8'hFF || lat !== N) begin
            $display("FAIL vinff: got %h lat %0d want ff lat %0d", res_cap, lat, N);
            fails++;
        end
        conv_run(8'h01, 0);
        tests++;
        if (res_cap !== 8'h01 || rv_cap !== 1'b1) begin
            $display("FAIL vin01: got %h/%b want 01/1", res_cap, rv_cap);
            fails++;
        end
    endtask

    task automatic test_start_while_busy();
        conv_run(8'hA5, 5);
        tests++;
        if (dones !== 1 || lat !== N || res_cap !== 8'hA5) begin
            $display("FAIL busy_start: got dones %0d lat %0d res %h want 1 %0d a5",
                     dones, lat, res_cap, N);
            fails++;
        end
    endtask

    task automatic test_ena_drop();
        int nd;
        vin = 8'h33;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        nd = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc();
            if (bus.done) nd++;
        end
        bus.ena = 1'b0;
        cyc();
        tests++;
        if (bus.busy !== 1'b0 || bus.sample_en !== 1'b0 || bus.dac_code !== 8'h00) begin
            $display("FAIL ena_abort: got busy %b se %b dac %h want 0 0 00",
                     bus.busy, bus.sample_en, bus.dac_code);
            fails++;
        end
        tests++;
        if (bus.result !== 8'hA5 || bus.result_valid !== 1'b0) begin
            $display("FAIL ena_result: got %h/%b want a5/0", bus.result, bus.result_valid);
            fails++;
        end
        bus.ena = 1'b1;
        for (int i = 0; i < N; i++) begin
            cyc();
            if (bus.done || bus.busy) nd++;
        end
        tests++;
        if (nd !== 0) begin
            $display("FAIL ena_no_done: got %0d activity cycles want 0", nd);
            fails++;
        end
    endtask

    task automatic test_async_reset();
        vin = 8'h77;
        bus.start = 1'b1;
        cyc();
        bus.start = 1'b0;
        for (int i = 1; i <= 4; i++) cyc();
        #2 rst = 1'b1;
        #1;
        tests++;
        if ({bus.sample_en, bus.dac_code, bus.busy, bus.done, bus.result, bus.result_valid} !== 20'h0) begin
            $display("FAIL async_reset: got %h want 0",
                     {bus.sample_en, bus.dac_code, bus.busy, bus.done, bus.result, bus.result_valid});
            fails++;
        end
        cyc();
        rst = 1'b0;
        cyc();
        conv_run(8'h5A, 0);
        tests++;
        if (res_cap !== 8'h5A || lat !== N || rv_cap !== 1'b1) begin
            $display("FAIL post_reset_conv: got %h lat %0d want 5a lat %0d", res_cap, lat, N);
            fails++;
        end
    endtask

    task automatic test_back_to_back();
        int d1, d2;
        d1 = -1; d2 = -1;
        vin = 8'h3C;
        bus.start = 1'b1;
        cyc();
        for (int i = 1; i <= 2 * N + 10; i++) begin
            cyc();
            if (bus.done) begin
                if (d1 < 0) d1 = i;
                else if (d2 < 0) d2 = i;
            end
        end
        bus.start = 1'b0;
        tests++;
        if (d1 !== N || bus.result !== 8'h3C) begin
            $display("FAIL b2b_first: got %0d res %h want %0d 3c", d1, bus.result, N);
            fails++;
        end
        tests++;
        if (d2 - d1 !== N + 2) begin
            $display("FAIL b2b_period: got %0d want %0d", d2 - d1, N + 2);
            fails++;
        end
        for (int i = 0; i < N + 5; i++) cyc();
    endtask

    initial begin
        bus.ena = 1'b1;
        bus.start = 1'b0;
        test_reset();
        test_vin_a5();
        test_boundaries();
        test_start_while_busy();
        test_ena_drop();
        test_async_reset();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
